column_height_buffer: RTL and testbench

Downstream consumer of the ray tracer's trace-buffer write port. On each `store` pulse it captures one column result: column index, side, distance and texture X. It converts the distance to an on-screen wall height with a fully pipelined reciprocal divider that accepts one result per clock. It writes height, side and tex into a per-column RAM, which the row renderer reads during active video.

---
 rtl/column_height_buffer.sv | 126 ++++++++++++
 tb/tb_column_height_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/column_height_buffer.sv
// rtl/column_height_buffer.sv - pipelined distance-to-height converter feeding a per-column RAM
// Stage 0 captures the tracer result; stages 1..10 run a restoring divide, one quotient bit each.
module column_height_buffer #(
  parameter int COLS     = 640,
  parameter int HEIGHT_K = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store,
  input  logic [9:0]  column,
  input  logic        side,
  input  logic [15:0] vdist,
  input  logic [5:0]  tex,
  input  logic [9:0]  rd_col,
  output logic [9:0]  rd_height,
  output logic        rd_side,
  output logic [5:0]  rd_tex,
  output logic        busy,
  output logic        frame_done
);

  localparam int          NUM      = HEIGHT_K * 512;
  localparam int          LAST     = 10;
  localparam logic [16:0] REM_INIT = 17'(NUM >> 10);
  localparam logic [9:0]  NUM_LO   = 10'(NUM);
  localparam logic [9:0]  LAST_COL = 10'(COLS - 1);

  logic [LAST:0] valid_q, valid_d;
  logic [9:0]    col_q  [LAST+1];
  logic [9:0]    col_d  [LAST+1];
  logic          side_q [LAST+1];
  logic          side_d [LAST+1];
  logic [5:0]    tex_q  [LAST+1];
  logic [5:0]    tex_d  [LAST+1];
  logic [15:0]   div_q  [LAST+1];
  logic [15:0]   div_d  [LAST+1];
  logic          sat_q  [LAST+1];
  logic          sat_d  [LAST+1];
  logic [16:0]   rem_q  [LAST+1];
  logic [16:0]   rem_d  [LAST+1];
  logic [9:0]    quo_q  [LAST+1];
  logic [9:0]    quo_d  [LAST+1];

  logic          busy_q, busy_d;
  logic [16:0]   rd_data_q, rd_data_d;
  logic [16:0]   mem [COLS];

  logic [16:0]   shifted;
  logic [31:0]   vdist_scaled;
  logic          ge;
  logic [9:0]    height_w;
  logic          wr_en;

  always_comb begin
    shifted      = '0;
    ge           = 1'b0;
    vdist_scaled = {6'b0, vdist, 10'b0};

    // Any quotient of 1024 or more saturates; flagged up front so the divider only needs 10 bits.
    valid_d[0] = store;
    col_d[0]   = column;
    side_d[0]  = side;
    tex_d[0]   = tex;
    div_d[0]   = vdist;
    sat_d[0]   = (vdist == 16'd0) || (vdist_scaled <= 32'(NUM));
    rem_d[0]   = REM_INIT;
    quo_d[0]   = '0;

    for (int i = 1; i <= LAST; i++) begin
      shifted    = {rem_q[i-1][15:0], NUM_LO[LAST-i]};
      ge         = (shifted >= {1'b0, div_q[i-1]});
      valid_d[i] = valid_q[i-1];
      col_d[i]   = col_q[i-1];
      side_d[i]  = side_q[i-1];
      tex_d[i]   = tex_q[i-1];
      div_d[i]   = div_q[i-1];
      sat_d[i]   = sat_q[i-1];
      rem_d[i]   = ge ? (shifted - {1'b0, div_q[i-1]}) : shifted;
      quo_d[i]   = {quo_q[i-1][8:0], ge};
    end

    busy_d    = |valid_d;
    rd_data_d = mem[rd_col];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i <= LAST; i++) begin
      col_q[i]  <= col_d[i];
      side_q[i] <= side_d[i];
      tex_q[i]  <= tex_d[i];
      div_q[i]  <= div_d[i];
      sat_q[i]  <= sat_d[i];
      rem_q[i]  <= rem_d[i];
      quo_q[i]  <= quo_d[i];
    end
  end

  // Reset suppresses the write of whatever sits in the last stage during the reset cycle.
  assign height_w   = sat_q[LAST] ? 10'd1023 : quo_q[LAST];
  assign wr_en      = !reset && valid_q[LAST] && ({22'b0, col_q[LAST]} < 32'(COLS));
  assign frame_done = wr_en && (col_q[LAST] == LAST_COL);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[col_q[LAST]] <= {height_w, side_q[LAST], tex_q[LAST]};
    end
  end

  assign busy      = busy_q;
  assign rd_height = rd_data_q[16:7];
  assign rd_side   = rd_data_q[6];
  assign rd_tex    = rd_data_q[5:0];

endmodule

// File: tb/tb_column_height_buffer.sv
// tb/tb_column_height_buffer.sv - randomized self-checking bench for column_height_buffer
// Expected heights come from integer division on a shadow copy of the column RAM.
module tb_column_height_buffer;

  logic        clk = 1'b0;
  logic        reset, store, side;
  logic [9:0]  column, rd_col;
  logic [15:0] vdist;
  logic [5:0]  tex;
  logic [9:0]  rd_height;
  logic        rd_side;
  logic [5:0]  rd_tex;
  logic        busy, frame_done;

  column_height_buffer #(.COLS(640), .HEIGHT_K(256)) dut (
    .clk(clk), .reset(reset), .store(store), .column(column), .side(side),
    .vdist(vdist), .tex(tex), .rd_col(rd_col), .rd_height(rd_height),
    .rd_side(rd_side), .rd_tex(rd_tex), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_total = 0;
  int m_h [640];
  int m_s [640];
  int m_t [640];
  int sat_v [5] = '{0, 128, 129, 65535, 2048};
  int sat_h [5] = '{1023, 1023, 1016, 2, 64};

  always @(negedge clk) if (frame_done) fd_total++;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_height(input int v);
    int q;
    if (v == 0) return 1023;
    q = (256 * 512) / v;
    return (q > 1023) ? 1023 : q;
  endfunction

  task automatic put(input int c, input int s, input int v, input int t, input bit upd);
    store  = 1'b1;
    column = 10'(c);
    side   = s[0];
    vdist  = 16'(v);
    tex    = 6'(t);
    if (upd && c < 640) begin
      m_h[c] = ref_height(v);
      m_s[c] = s & 1;
      m_t[c] = t & 63;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      store = 1'b0;
    end
  endtask

  task automatic read_col(input int c, output int h, output int s, output int t);
    @(negedge clk);
    rd_col = 10'(c);
    @(negedge clk);
    h = rd_height;
    s = rd_side;
    t = rd_tex;
  endtask

  initial begin
    int h, s, t, fd_before, fd_at, b10, b11, n639, c, v;

    reset = 1'b1; store = 1'b1; column = 10'd639; vdist = 16'd512;
    side = 1'b0; tex = 6'd0; rd_col = 10'd0;
    repeat (3) @(negedge clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_frame_done", frame_done, 0);
    check_val("reset_rd_height", rd_height, 0);
    check_val("reset_rd_side", rd_side, 0);
    check_val("reset_rd_tex", rd_tex, 0);
    reset = 1'b0; store = 1'b0;
    @(negedge clk);
    check_val("store_during_reset_busy", busy, 0);

    @(negedge clk); put(5, 1, 512, 33, 1'b1);
    @(negedge clk); store = 1'b0;
    check_val("busy_rise", busy, 1);
    idle(12);
    check_val("store_during_reset_fd", fd_total, 0);
    read_col(5, h, s, t);
    check_val("basic_height", h, 256);
    check_val("basic_side", s, 1);
    check_val("basic_tex", t, 33);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk); put(10 + i, i % 2, sat_v[i], i, 1'b1);
    end
    idle(13);
    for (int i = 0; i < 5; i++) begin
      read_col(10 + i, h, s, t);
      check_val($sformatf("sat_height_v%0d", sat_v[i]), h, sat_h[i]);
    end

    @(negedge clk); put(7, 1, 512, 9, 1'b1);
    idle(13);
    @(negedge clk); rd_col = 10'd7; put(7, 0, 1024, 5, 1'b1);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk); store = 1'b0;
      if (k == 11) check_val("collide_old", rd_height, 256);
      if (k == 12) check_val("collide_new", rd_height, 128);
    end

    fd_before = fd_total;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk); put(i, int'($urandom_range(0, 1)), 512 + i, int'($urandom_range(0, 63)), 1'b1);
    end
    fd_at = -1; b10 = -1; b11 = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); store = 1'b0;
      if (frame_done) fd_at = k;
      if (k == 10) b10 = busy;
      if (k == 11) b11 = busy;
    end
    check_val("full_fd_count", fd_total - fd_before, 1);
    check_val("full_fd_cycle", fd_at, 10);
    check_val("full_busy_at_fd", b10, 1);
    check_val("full_busy_after_fd", b11, 0);
    for (int i = 0; i < 640; i++) begin
      read_col(i, h, s, t);
      check_val($sformatf("full_h%0d", i), h, 131072 / (512 + i));
      check_val($sformatf("full_s%0d", i), s, m_s[i]);
      check_val($sformatf("full_t%0d", i), t, m_t[i]);
    end

    fd_before = fd_total; n639 = 0;
    for (int it = 0; it < 500; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) store = 1'b0;
      else begin
        c = ($urandom_range(0, 7) == 0) ? 639 : int'($urandom_range(0, 1023));
        v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 65535));
        put(c, int'($urandom_range(0, 1)), v, int'($urandom_range(0, 63)), 1'b1);
        if (c == 639) n639++;
      end
    end
    idle(14);
    check_val("rand_fd_count", fd_total - fd_before, n639);
    for (int i = 0; i < 640; i++) begin
      read_col(i, h, s, t);
      check_val($sformatf("rand_h%0d", i), h, m_h[i]);
      check_val($sformatf("rand_s%0d", i), s, m_s[i]);
      check_val($sformatf("rand_t%0d", i), t, m_t[i]);
    end

    @(negedge clk); put(640, 1, 300, 63, 1'b1);
    @(negedge clk); put(1023, 1, 300, 63, 1'b1);
    idle(14);
    read_col(0, h, s, t);   check_val("sentinel_c0", h, m_h[0]);
    read_col(128, h, s, t); check_val("sentinel_c128", h, m_h[128]);
    read_col(383, h, s, t); check_val("sentinel_c383", h, m_h[383]);

    fd_before = fd_total;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); put(20 + i, 1, 700 + i, i, 1'b0);
    end
    idle(4);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_val("midreset_busy", busy, 0);
    check_val("midreset_rd_height", rd_height, 0);
    check_val("midreset_rd_side", rd_side, 0);
    check_val("midreset_rd_tex", rd_tex, 0);
    idle(14);
    check_val("midreset_fd", fd_total - fd_before, 0);
    for (int i = 0; i < 5; i++) begin
      read_col(20 + i, h, s, t);
      check_val($sformatf("midreset_h%0d", 20 + i), h, m_h[20 + i]);
      check_val($sformatf("midreset_t%0d", 20 + i), t, m_t[20 + i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
